// File: rtl/reg_xfer_arb.sv
// reg_xfer_arb: arbitrates two requesters for a register-to-register move.
// A grant drives the source register onto the bus for OE_CYCLES cycles
// (DRIVE), strobes the destination load for one cycle (LOAD), then pulses
// the winner's ack for one cycle (DONE) before returning to IDLE.
//
// Parameter: OE_CYCLES (1..8) source drive cycles before the load strobe.
// Macro RR_ARB_EN: round-robin arbitration on simultaneous requests;
// undefined gives fixed priority with requester 0 winning.
//
// Ports:
//   clk, reset (async, active-low)
//   req0/src0/dst0/ack0, req1/src1/dst1/ack1  requester handshakes
//   s_adr/s_en   register-file output-enable decoder
//   w_adr/w_en   register-file load decoder
//   busy         high outside IDLE
//   gnt_id       requester being served (valid while busy)
module reg_xfer_arb #(
    parameter int OE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [2:0] src0,
    input  logic [2:0] dst0,
    output logic       ack0,
    input  logic       req1,
    input  logic [2:0] src1,
    input  logic [2:0] dst1,
    output logic       ack1,
    output logic [2:0] s_adr,
    output logic       s_en,
    output logic [2:0] w_adr,
    output logic       w_en,
    output logic       busy,
    output logic       gnt_id
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LOAD,
        DONE
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(OE_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic [2:0] src_q;
    logic [2:0] dst_q;
    logic       gnt_q;
    logic       win;
    logic       start;

    assign start = (state == IDLE) && (req0 || req1);

`ifdef RR_ARB_EN
    // Requester served by the most recent grant; a tie goes to the other.
    logic last_q;

    always_comb begin
        win = 1'b0;
        if (req0 && req1)
            win = ~last_q;
        else
            win = req1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_q <= 1'b1;
        else if (start)
            last_q <= win;
    end
`else
    always_comb begin
        win = ~req0 & req1;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req0 || req1) state_nx = DRIVE;
            DRIVE:   if (cnt == CNT_LAST) state_nx = LOAD;
            LOAD:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The transfer is captured at the grant so the requester may change
    // its src/dst inputs freely while it is being served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 3'd0;
            src_q <= 3'd0;
            dst_q <= 3'd0;
            gnt_q <= 1'b0;
        end else begin
            if (start) begin
                gnt_q <= win;
                src_q <= win ? src1 : src0;
                dst_q <= win ? dst1 : dst0;
            end
            if (state == DRIVE)
                cnt <= (cnt == CNT_LAST) ? 3'd0 : cnt + 3'd1;
        end
    end

    // Outputs decode straight from state so reset clears them at once.
    always_comb begin
        s_en  = 1'b0;
        s_adr = 3'd0;
        w_en  = 1'b0;
        w_adr = 3'd0;
        ack0  = 1'b0;
        ack1  = 1'b0;
        unique case (state)
            DRIVE: begin
                s_en  = 1'b1;
                s_adr = src_q;
            end
            LOAD: begin
                s_en  = 1'b1;
                s_adr = src_q;
                w_en  = 1'b1;
                w_adr = dst_q;
            end
            DONE: begin
                ack0 = ~gnt_q;
                ack1 = gnt_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign gnt_id = gnt_q;

endmodule

// File: tb/tb_reg_xfer_arb.sv
// tb_reg_xfer_arb: two arbiters (OE_CYCLES 1 and 4) against a
// transaction-timeline reference model, directed cases then random traffic.
module tb_reg_xfer_arb;

    localparam int NA = 1;
    localparam int NB = 4;
`ifdef RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       req [2][2];
    logic [2:0] src [2][2];
    logic [2:0] dst [2][2];
    logic       ack [2][2];
    logic [2:0] s_adr [2];
    logic [2:0] w_adr [2];
    logic       s_en [2];
    logic       w_en [2];
    logic       busy [2];
    logic       gnt_id [2];

    reg_xfer_arb #(.OE_CYCLES(NA)) u_a (
        .clk(clk), .reset(rst_n),
        .req0(req[0][0]), .src0(src[0][0]), .dst0(dst[0][0]),
        .ack0(ack[0][0]),
        .req1(req[0][1]), .src1(src[0][1]), .dst1(dst[0][1]),
        .ack1(ack[0][1]),
        .s_adr(s_adr[0]), .s_en(s_en[0]),
        .w_adr(w_adr[0]), .w_en(w_en[0]),
        .busy(busy[0]), .gnt_id(gnt_id[0])
    );

    reg_xfer_arb #(.OE_CYCLES(NB)) u_b (
        .clk(clk), .reset(rst_n),
        .req0(req[1][0]), .src0(src[1][0]), .dst0(dst[1][0]),
        .ack0(ack[1][0]),
        .req1(req[1][1]), .src1(src[1][1]), .dst1(dst[1][1]),
        .ack1(ack[1][1]),
        .s_adr(s_adr[1]), .s_en(s_en[1]),
        .w_adr(w_adr[1]), .w_en(w_en[1]),
        .busy(busy[1]), .gnt_id(gnt_id[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int nn [2];
    bit rand_en;
    bit keep [2][2];
    bit served [2][$];

    // Reference model: a transfer granted at edge t0 occupies cycles
    // t0..t0+N-1 driving, t0+N loading, t0+N+1 acking.
    bit         m_act [2];
    bit         m_gnt [2];
    bit         m_last [2];
    logic [2:0] m_src [2];
    logic [2:0] m_dst [2];
    int         m_t0 [2];

    task automatic chk(string tag, int unsigned obs, int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset(int d);
        m_act[d]  = 1'b0;
        m_gnt[d]  = 1'b0;
        m_last[d] = 1'b1;
        m_src[d]  = 3'd0;
        m_dst[d]  = 3'd0;
        m_t0[d]   = 0;
    endfunction

    function automatic void model_edge(int d);
        bit w;
        if (!rst_n) begin
            model_reset(d);
        end else if (m_act[d]) begin
            if (cyc - m_t0[d] == nn[d] + 2)
                m_act[d] = 1'b0;
        end else if (req[d][0] || req[d][1]) begin
            if (req[d][0] && req[d][1])
                w = RR ? ~m_last[d] : 1'b0;
            else
                w = req[d][1];
            m_gnt[d]  = w;
            m_last[d] = w;
            m_act[d]  = 1'b1;
            m_t0[d]   = cyc;
            m_src[d]  = src[d][w];
            m_dst[d]  = dst[d][w];
        end
    endfunction

    function automatic logic [11:0] exp_vec(int d);
        int k;
        bit g;
        if (!m_act[d])
            return 12'd0;
        k = cyc - m_t0[d];
        g = m_gnt[d];
        if (k < nn[d])
            return {1'b1, g, 1'b1, m_src[d], 1'b0, 3'd0, 2'b00};
        if (k == nn[d])
            return {1'b1, g, 1'b1, m_src[d], 1'b1, m_dst[d], 2'b00};
        return {1'b1, g, 1'b0, 3'd0, 1'b0, 3'd0, g, ~g};
    endfunction

    function automatic logic [11:0] obs_vec(int d);
        return {busy[d], busy[d] & gnt_id[d], s_en[d], s_adr[d],
                w_en[d], w_adr[d], ack[d][1], ack[d][0]};
    endfunction

    task automatic new_xfer(int d, int r);
        src[d][r] = 3'($urandom_range(0, 7));
        dst[d][r] = ($urandom_range(0, 3) == 0) ? src[d][r]
                                                : 3'($urandom_range(0, 7));
    endtask

    task automatic put(int d, int r, int s, int t);
        req[d][r] = 1'b1;
        src[d][r] = 3'(s);
        dst[d][r] = 3'(t);
    endtask

    task automatic agent(int d);
        for (int r = 0; r < 2; r++) begin
            if (ack[d][r]) begin
                served[d].push_back(bit'(r));
                if (keep[d][r] || (rand_en && $urandom_range(0, 3) == 0)) begin
                    if (rand_en)
                        new_xfer(d, r);
                end else begin
                    req[d][r] = 1'b0;
                end
            end else if (req[d][r]) begin
                if (rand_en && $urandom_range(0, 3) == 0)
                    new_xfer(d, r);
            end else if (rand_en && $urandom_range(0, 5) == 0) begin
                req[d][r] = 1'b1;
                new_xfer(d, r);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++)
            model_edge(d);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cyc%0d_i%0d", cyc, d), obs_vec(d), exp_vec(d));
            agent(d);
        end
    endtask

    task automatic pulse_rst(int cycles);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++)
            model_reset(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_out_i%0d", d), obs_vec(d), 0);
            chk($sformatf("rst_gnt_i%0d", d), gnt_id[d], 0);
        end
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat [2];
        int sen [2];
        int wen [2];
        int got [2];
        bit seen;
        logic [3:0] ord;

        nn[0]   = NA;
        nn[1]   = NB;
        rand_en = 1'b0;
        rst_n   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            for (int r = 0; r < 2; r++) begin
                req[d][r]  = 1'b0;
                src[d][r]  = 3'd0;
                dst[d][r]  = 3'd0;
                keep[d][r] = 1'b0;
            end
        end
        @(negedge clk);
        pulse_rst(2);
        step();

        // Single transfer latency and enable widths.
        put(0, 0, 3, 5);
        put(1, 1, 7, 0);
        for (int d = 0; d < 2; d++) begin
            lat[d] = 0;
            sen[d] = 0;
            wen[d] = 0;
        end
        for (int i = 1; i <= 20; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                sen[d] += int'(s_en[d]);
                wen[d] += int'(w_en[d]);
                if ((ack[d][0] || ack[d][1]) && lat[d] == 0)
                    lat[d] = i;
            end
        end
        chk("lat_a", lat[0], NA + 2);
        chk("lat_b", lat[1], NB + 2);
        chk("sen_a", sen[0], NA + 1);
        chk("sen_b", sen[1], NB + 1);
        chk("wen_a", wen[0], 1);
        chk("wen_b", wen[1], 1);

        // Both requests held from reset: service order.
        for (int d = 0; d < 2; d++) begin
            served[d].delete();
            put(d, 0, 1, 2);
            put(d, 1, 4, 3);
            keep[d][0] = 1'b1;
            keep[d][1] = 1'b1;
        end
        pulse_rst(1);
        repeat (32) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("order_n_i%0d", d), served[d].size() >= 4, 1);
            ord = 4'd0;
            for (int i = 0; i < 4 && i < served[d].size(); i++)
                ord[3 - i] = served[d][i];
            chk($sformatf("order_i%0d", d), ord, RR ? 4'b0101 : 4'b0000);
            keep[d][0] = 1'b0;
            keep[d][1] = 1'b0;
        end
        repeat (30) step();

        // Reset during LOAD aborts; the held request is re-served.
        put(0, 0, 1, 1);
        put(1, 0, 2, 4);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            seen = w_en[1];
        end
        chk("load_seen", seen, 1);
        pulse_rst(2);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (ack[1][0])
                seen = 1'b1;
        end
        chk("reserve", seen, 1);
        repeat (4) step();

        // req1 arrives while requester 0 is driving.
        for (int d = 0; d < 2; d++) begin
            served[d].delete();
            got[d] = 0;
            put(d, 0, 1, 2);
        end
        step();
        for (int d = 0; d < 2; d++)
            put(d, 1, 4, 6);
        step();
        for (int d = 0; d < 2; d++) begin
            src[d][1] = 3'd5;
            dst[d][1] = 3'd3;
        end
        for (int i = 0; i < 20; i++) begin
            step();
            for (int d = 0; d < 2; d++)
                if (busy[d] && gnt_id[d] && s_en[d])
                    got[d] = int'(s_adr[d]);
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("pend_src_i%0d", d), got[d], 5);
            ord = 4'd0;
            for (int i = 0; i < 2 && i < served[d].size(); i++)
                ord[1 - i] = served[d][i];
            chk($sformatf("pend_n_i%0d", d), served[d].size(), 2);
            chk($sformatf("pend_ord_i%0d", d), ord, 4'b0001);
        end

        // src == dst runs the ordinary sequence.
        for (int d = 0; d < 2; d++) begin
            put(d, 1, 6, 6);
            got[d] = 0;
        end
        for (int i = 0; i < 10; i++) begin
            step();
            for (int d = 0; d < 2; d++)
                if (w_en[d])
                    got[d] = int'({s_adr[d], w_adr[d]});
        end
        for (int d = 0; d < 2; d++)
            chk($sformatf("same_i%0d", d), got[d], 6'o66);

        // Random traffic with occasional resets.
        rand_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0)
                pulse_rst(1);
            else
                step();
        end
        rand_en = 1'b0;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
